// File: rtl/mdu_iter.sv
//------------------------------------------------------------------------------
// mdu_iter : radix-2 iterative signed multiply/divide unit (MUL, MULH, DIV, REM)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             div_zero_o
);

   localparam logic [1:0] c_OP_MUL  = 2'b00;
   localparam logic [1:0] c_OP_MULH = 2'b01;
   localparam logic [1:0] c_OP_DIV  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             r_state;
   logic [1:0]         r_op;
   logic               r_sign1;
   logic               r_sign2;
   logic               r_dz;
   logic [WIDTH-1:0]   r_opnd;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_result;
   logic               r_div_zero;

   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic               w_start_dz;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_div_sh;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_sub;
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_quot_s;
   logic [WIDTH-1:0]   w_rem_s;
   logic [WIDTH-1:0]   w_src1_back;
   logic [WIDTH-1:0]   w_fix_res;

   assign w_abs1     = src1_i[WIDTH-1] ? -src1_i : src1_i;
   assign w_abs2     = src2_i[WIDTH-1] ? -src2_i : src2_i;
   assign w_start_dz = op_i[1] && (src2_i == '0);

   // Multiplier sits in the low half and is consumed LSB-first while the
   // partial product grows into the upper half; the carry bit is kept.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};

   // Remainder is always below the divisor (<= 2^(WIDTH-1)), so the bit
   // shifted out of the top is always zero.
   assign w_div_sh  = {r_acc[2*WIDTH-2:0], 1'b0};
   assign w_div_ge  = (w_div_sh[2*WIDTH-1:WIDTH] >= r_opnd);
   assign w_div_sub = w_div_sh[2*WIDTH-1:WIDTH] - r_opnd;

   assign w_prod_s    = (r_sign1 ^ r_sign2) ? -r_acc : r_acc;
   assign w_quot_s    = (r_sign1 ^ r_sign2) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem_s     = r_sign1 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_src1_back = r_sign1 ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   always_comb begin
      w_fix_res = '0;
      if (r_dz) begin
         w_fix_res = (r_op == c_OP_DIV) ? {WIDTH{1'b1}} : w_src1_back;
      end else begin
         case (r_op)
            c_OP_MUL:  w_fix_res = w_prod_s[WIDTH-1:0];
            c_OP_MULH: w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
            c_OP_DIV:  w_fix_res = w_quot_s;
            default:   w_fix_res = w_rem_s;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_sign1    <= 1'b0;
         r_sign2    <= 1'b0;
         r_dz       <= 1'b0;
         r_opnd     <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_op       <= op_i;
                  r_sign1    <= src1_i[WIDTH-1];
                  r_sign2    <= src2_i[WIDTH-1];
                  r_dz       <= w_start_dz;
                  r_opnd     <= op_i[1] ? w_abs2 : w_abs1;
                  r_acc      <= {{WIDTH{1'b0}}, (op_i[1] ? w_abs1 : w_abs2)};
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_div_zero <= 1'b0;
                  r_state    <= w_start_dz ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               if (r_op[1]) begin
                  r_acc <= {(w_div_ge ? w_div_sub : w_div_sh[2*WIDTH-1:WIDTH]),
                            w_div_sh[WIDTH-1:1], w_div_ge};
               end else if (r_acc[0]) begin
                  r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
               end else begin
                  r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(WIDTH-1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result   <= w_fix_res;
               r_div_zero <= r_dz;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= S_DONE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign result_o   = r_result;
   assign div_zero_o = r_div_zero;

endmodule

`default_nettype wire
